// File: rtl/av2_recon_writer.sv
`default_nettype none
// ============================================================================
//  Module   : av2_recon_writer
//  Purpose  : Packs a tile's reconstructed pixel stream into LANES-wide words,
//             queues them in a small FIFO and writes them to consecutive
//             word addresses with valid/ready back-pressure.
//  Revision : 1.0  initial release
// ============================================================================
module av2_recon_writer #(
    parameter int PIX_W      = 10,
    parameter int LANES      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [CNT_W-1:0]       pix_count,
    input  logic [PIX_W-1:0]       pix_data,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    output logic [LANES*PIX_W-1:0] wr_data,
    output logic [LANES-1:0]       wr_mask,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int c_WORD_W = LANES * PIX_W;
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_OCC_W  = c_PTR_W + 1;
    localparam int c_LANE_W = $clog2(LANES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PACK  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_LANE_W-1:0]   r_lane;
    logic [CNT_W-1:0]      r_remaining;
    logic [ADDR_W-1:0]     r_next_addr;
    logic [c_WORD_W-1:0]   r_pack_data;
    logic [LANES-1:0]      r_pack_mask;

    logic [c_WORD_W-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [LANES-1:0]      r_fifo_mask [FIFO_DEPTH];
    logic [ADDR_W-1:0]     r_fifo_addr [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_OCC_W-1:0]    r_occ;
    logic [c_OCC_W-1:0]    w_occ_next;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_pix_fire;
    logic                  w_last_pix;
    logic                  w_push;
    logic                  w_pop;
    logic [c_WORD_W-1:0]   w_word;
    logic [LANES-1:0]      w_mask;

    assign w_full     = (r_occ == c_OCC_W'(FIFO_DEPTH));
    assign w_empty    = (r_occ == '0);
    assign pix_ready  = (r_state == S_PACK) && !w_full;
    assign w_pix_fire = pix_valid && pix_ready;
    assign w_last_pix = (r_remaining == CNT_W'(1));
    assign w_push     = w_pix_fire && ((r_lane == c_LANE_W'(LANES - 1)) || w_last_pix);
    assign w_pop      = !w_empty && wr_ready;
    assign w_occ_next = r_occ + c_OCC_W'(w_push) - c_OCC_W'(w_pop);

    // Packer keeps unfilled lanes at zero, so a partial word needs no masking later.
    always_comb begin
        w_word = r_pack_data;
        w_mask = r_pack_mask;
        for (int k = 0; k < LANES; k++) begin
            if (r_lane == c_LANE_W'(k)) begin
                w_word[k*PIX_W +: PIX_W] = pix_data;
                w_mask[k]                = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = (pix_count == '0) ? S_DONE : S_PACK;
            S_PACK:  if (w_pix_fire && w_last_pix) w_state_next = S_DRAIN;
            // Look ahead so done follows the acceptance of the last word directly.
            S_DRAIN: if (w_occ_next == '0) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lane      <= '0;
            r_remaining <= '0;
            r_next_addr <= '0;
            r_pack_data <= '0;
            r_pack_mask <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
        end else begin
            r_state <= w_state_next;
            if (start && (r_state == S_IDLE)) begin
                r_remaining <= pix_count;
                r_next_addr <= base_addr;
                r_lane      <= '0;
                r_pack_data <= '0;
                r_pack_mask <= '0;
            end
            if (w_pix_fire) begin
                r_remaining <= r_remaining - CNT_W'(1);
                if (w_push) begin
                    r_lane      <= '0;
                    r_pack_data <= '0;
                    r_pack_mask <= '0;
                    r_next_addr <= r_next_addr + ADDR_W'(1);
                end else begin
                    r_lane      <= r_lane + c_LANE_W'(1);
                    r_pack_data <= w_word;
                    r_pack_mask <= w_mask;
                end
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_occ <= w_occ_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_word;
            r_fifo_mask[r_wr_ptr] <= w_mask;
            r_fifo_addr[r_wr_ptr] <= r_next_addr;
        end
    end

    // Head is gated while empty so the write port reads all-zero when idle.
    assign wr_valid = !w_empty;
    assign wr_data  = w_empty ? '0 : r_fifo_data[r_rd_ptr];
    assign wr_mask  = w_empty ? '0 : r_fifo_mask[r_rd_ptr];
    assign wr_addr  = w_empty ? '0 : r_fifo_addr[r_rd_ptr];
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_av2_recon_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_av2_recon_writer
//  Purpose  : Directed self-checking bench for av2_recon_writer (8-bit pixels,
//             16 lanes, 4-entry FIFO).
//  Revision : 1.0  initial release
// ============================================================================
module tb_av2_recon_writer;

    localparam int PIX_W      = 8;
    localparam int LANES      = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 32;
    localparam int CNT_W      = 16;
    localparam int WORD_W     = PIX_W * LANES;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  pix_count;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [WORD_W-1:0] wr_data;
    logic [LANES-1:0]  wr_mask;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_valid;
    logic              wr_ready;
    logic              busy;
    logic              done;

    av2_recon_writer #(
        .PIX_W(PIX_W), .LANES(LANES), .FIFO_DEPTH(FIFO_DEPTH),
        .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .pix_count(pix_count), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_addr(wr_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_acc_cyc = 0;

    logic [WORD_W-1:0] q_data [$];
    logic [LANES-1:0]  q_mask [$];
    logic [ADDR_W-1:0] q_addr [$];

    localparam logic [WORD_W-1:0] T2_W0 = 128'h100F0E0D0C0B0A09_0807060504030201;
    localparam logic [WORD_W-1:0] T2_W1 = 128'h0000000000000000_0000000014131211;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write handshake that will complete at the next rising edge.
    always @(negedge clk) begin
        if (!rst && wr_valid && wr_ready) begin
            q_data.push_back(wr_data);
            q_mask.push_back(wr_mask);
            q_addr.push_back(wr_addr);
            last_acc_cyc = cyc;
        end
    end

    function automatic logic [WORD_W-1:0] exp_data(int sv, int cnt, int n);
        logic [WORD_W-1:0] d = '0;
        for (int k = 0; k < LANES; k++)
            if (n * LANES + k < cnt) d[k*PIX_W +: PIX_W] = PIX_W'(sv + n * LANES + k);
        return d;
    endfunction

    function automatic logic [LANES-1:0] exp_mask(int cnt, int n);
        logic [LANES-1:0] m = '0;
        for (int k = 0; k < LANES; k++)
            if (n * LANES + k < cnt) m[k] = 1'b1;
        return m;
    endfunction

    task automatic clear_log();
        q_data.delete();
        q_mask.delete();
        q_addr.delete();
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input int n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; pix_count = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Pixel i carries value sv+i; returns the number of cycles spent.
    task automatic feed(input int n, input int sv, output int used, output bit ok);
        bit acc;
        ok = 1'b1;
        used = 0;
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_data  = PIX_W'(sv + i);
            acc = 1'b0;
            while (!acc) begin
                @(negedge clk);
                acc = pix_ready;
                @(posedge clk); #1;
                used++;
                if (used > 4000) begin ok = 1'b0; break; end
            end
            if (!ok) break;
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_done(output int dcyc, output bit ok);
        ok = 1'b0;
        dcyc = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; dcyc = cyc; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; pix_count = '0;
        pix_data = '0; pix_valid = 1'b0; wr_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL reset_pix_ready got %b want 0", pix_ready); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
        checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
        checks++; if (wr_mask !== '0) begin errors++; $display("FAIL reset_wr_mask got %h want 0", wr_mask); end
        checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got %h want 0", wr_addr); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_full_words();
        int used, dcyc;
        bit ok, dok;
        clear_log();
        wr_ready = 1'b1;
        do_start(32'h100, 64);
        feed(64, 0, used, ok);
        checks++; if (!ok || used !== 64) begin errors++; $display("FAIL t1_pixel_rate got %0d cycles ok=%b want 64", used, ok); end
        wait_done(dcyc, dok);
        checks++; if (!dok) begin errors++; $display("FAIL t1_done_timeout got none want pulse"); end
        checks++; if (q_addr.size() !== 4) begin errors++; $display("FAIL t1_write_count got %0d want 4", q_addr.size()); end
        for (int n = 0; n < 4 && n < q_addr.size(); n++) begin
            checks++; if (q_addr[n] !== 32'h100 + 32'(n)) begin errors++; $display("FAIL t1_addr[%0d] got %h want %h", n, q_addr[n], 32'h100 + 32'(n)); end
            checks++; if (q_mask[n] !== 16'hFFFF) begin errors++; $display("FAIL t1_mask[%0d] got %h want ffff", n, q_mask[n]); end
            checks++; if (q_data[n] !== exp_data(0, 64, n)) begin errors++; $display("FAIL t1_data[%0d] got %h want %h", n, q_data[n], exp_data(0, 64, n)); end
        end
        checks++; if (dok && dcyc !== last_acc_cyc + 1) begin errors++; $display("FAIL t1_done_latency got cyc %0d want %0d", dcyc, last_acc_cyc + 1); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t1_after_done got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_partial_word();
        int used, dcyc;
        bit ok, dok;
        clear_log();
        wr_ready = 1'b1;
        do_start(32'h100, 20);
        feed(20, 1, used, ok);
        wait_done(dcyc, dok);
        checks++; if (!ok || !dok) begin errors++; $display("FAIL t2_complete got feed=%b done=%b want 1 1", ok, dok); end
        checks++; if (q_addr.size() !== 2) begin errors++; $display("FAIL t2_write_count got %0d want 2", q_addr.size()); end
        if (q_addr.size() >= 2) begin
            checks++; if (q_addr[0] !== 32'h100 || q_mask[0] !== 16'hFFFF || q_data[0] !== T2_W0) begin errors++; $display("FAIL t2_word0 got %h/%h/%h want 100/ffff/%h", q_addr[0], q_mask[0], q_data[0], T2_W0); end
            checks++; if (q_addr[1] !== 32'h101 || q_mask[1] !== 16'h000F || q_data[1] !== T2_W1) begin errors++; $display("FAIL t2_word1 got %h/%h/%h want 101/000f/%h", q_addr[1], q_mask[1], q_data[1], T2_W1); end
        end
    endtask

    task automatic test_backpressure();
        int used, dcyc, unstable;
        bit ok, dok, have;
        logic [WORD_W-1:0] held;
        logic [ADDR_W-1:0] held_addr;
        clear_log();
        wr_ready = 1'b0;
        have = 1'b0; unstable = 0; held = '0; held_addr = '0;
        do_start(32'h300, 128);
        fork
            feed(128, 5, used, ok);
            begin
                // Stall long enough for the FIFO to fill completely.
                repeat (80) begin
                    @(negedge clk);
                    if (wr_valid) begin
                        if (!have) begin held = wr_data; held_addr = wr_addr; have = 1'b1; end
                        else if (wr_data !== held || wr_addr !== held_addr) unstable++;
                    end
                end
                checks++; if (pix_ready !== 1'b0 || wr_valid !== 1'b1) begin errors++; $display("FAIL t3_full_stall got pix_ready=%b wr_valid=%b want 0 1", pix_ready, wr_valid); end
                checks++; if (unstable !== 0) begin errors++; $display("FAIL t3_head_stable got %0d changes want 0", unstable); end
                checks++; if (held !== exp_data(5, 128, 0) || held_addr !== 32'h300) begin errors++; $display("FAIL t3_head_word got %h@%h want %h@300", held, held_addr, exp_data(5, 128, 0)); end
                @(posedge clk); #1;
                wr_ready = 1'b1;
            end
        join
        wait_done(dcyc, dok);
        checks++; if (!ok || !dok) begin errors++; $display("FAIL t3_complete got feed=%b done=%b want 1 1", ok, dok); end
        checks++; if (q_addr.size() !== 8) begin errors++; $display("FAIL t3_write_count got %0d want 8", q_addr.size()); end
        for (int n = 0; n < 8 && n < q_addr.size(); n++) begin
            checks++;
            if (q_addr[n] !== 32'h300 + 32'(n) || q_mask[n] !== 16'hFFFF || q_data[n] !== exp_data(5, 128, n)) begin
                errors++;
                $display("FAIL t3_word[%0d] got %h/%h/%h want %h/ffff/%h", n, q_addr[n], q_mask[n], q_data[n], 32'h300 + 32'(n), exp_data(5, 128, n));
            end
        end
    endtask

    task automatic test_zero_count();
        int seen;
        clear_log();
        wr_ready = 1'b1;
        do_start(32'h400, 0);
        @(negedge clk);
        checks++; if (done !== 1'b1 || busy !== 1'b1 || wr_valid !== 1'b0) begin errors++; $display("FAIL t4_done_cycle got done=%b busy=%b wr_valid=%b want 1 1 0", done, busy, wr_valid); end
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy || wr_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL t4_after_done got %0d active cycles want 0", seen); end
        checks++; if (q_addr.size() !== 0) begin errors++; $display("FAIL t4_writes got %0d want 0", q_addr.size()); end
    endtask

    task automatic test_back_to_back();
        int used, d1, d2;
        bit ok1, ok2, dk1, dk2;
        logic [ADDR_W-1:0] ea [4];
        logic [WORD_W-1:0] ed [4];
        clear_log();
        wr_ready = 1'b1;
        do_start(32'h0, 32);
        fork
            feed(32, 8'h40, used, ok1);
            begin
                repeat (5) @(posedge clk);
                #1; start = 1'b1; base_addr = 32'h500; pix_count = CNT_W'(3);
                @(posedge clk); #1; start = 1'b0;
            end
        join
        wait_done(d1, dk1);
        do_start(32'hFFFF_FFFF, 32);
        feed(32, 8'h80, used, ok2);
        wait_done(d2, dk2);
        checks++; if (!ok1 || !ok2 || !dk1 || !dk2) begin errors++; $display("FAIL t5_complete got %b%b%b%b want 1111", ok1, ok2, dk1, dk2); end
        ea[0] = 32'h0; ea[1] = 32'h1; ea[2] = 32'hFFFF_FFFF; ea[3] = 32'h0;
        ed[0] = exp_data(8'h40, 32, 0); ed[1] = exp_data(8'h40, 32, 1);
        ed[2] = exp_data(8'h80, 32, 0); ed[3] = exp_data(8'h80, 32, 1);
        checks++; if (q_addr.size() !== 4) begin errors++; $display("FAIL t5_write_count got %0d want 4", q_addr.size()); end
        for (int n = 0; n < 4 && n < q_addr.size(); n++) begin
            checks++;
            if (q_addr[n] !== ea[n] || q_data[n] !== ed[n] || q_mask[n] !== 16'hFFFF) begin
                errors++;
                $display("FAIL t5_word[%0d] got %h/%h/%h want %h/ffff/%h", n, q_addr[n], q_mask[n], q_data[n], ea[n], ed[n]);
            end
        end
    endtask

    task automatic test_reset_mid_tile();
        int used, dcyc, seen;
        bit ok, dok;
        clear_log();
        wr_ready = 1'b0;
        do_start(32'h600, 64);
        feed(40, 0, used, ok);
        @(negedge clk);
        checks++; if (!ok || wr_valid !== 1'b1 || pix_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL t6_pre_reset got ok=%b wr_valid=%b pix_ready=%b busy=%b want 1111", ok, wr_valid, pix_ready, busy); end
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++; if (wr_valid !== 1'b0 || busy !== 1'b0 || pix_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL t6_post_reset got wr_valid=%b busy=%b pix_ready=%b done=%b want 0000", wr_valid, busy, pix_ready, done); end
        wr_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (wr_valid || done || busy) seen++;
        end
        checks++; if (seen !== 0 || q_addr.size() !== 0) begin errors++; $display("FAIL t6_abandoned got %0d active cycles %0d writes want 0 0", seen, q_addr.size()); end
        do_start(32'h200, 20);
        feed(20, 1, used, ok);
        wait_done(dcyc, dok);
        checks++; if (!ok || !dok || q_addr.size() !== 2) begin errors++; $display("FAIL t6_new_tile got feed=%b done=%b writes=%0d want 1 1 2", ok, dok, q_addr.size()); end
        if (q_addr.size() >= 2) begin
            checks++; if (q_addr[0] !== 32'h200 || q_mask[0] !== 16'hFFFF || q_data[0] !== T2_W0) begin errors++; $display("FAIL t6_word0 got %h/%h/%h want 200/ffff/%h", q_addr[0], q_mask[0], q_data[0], T2_W0); end
            checks++; if (q_addr[1] !== 32'h201 || q_mask[1] !== 16'h000F || q_data[1] !== T2_W1) begin errors++; $display("FAIL t6_word1 got %h/%h/%h want 201/000f/%h", q_addr[1], q_mask[1], q_data[1], T2_W1); end
        end
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_partial_word();
        test_backpressure();
        test_zero_count();
        test_back_to_back();
        test_reset_mid_tile();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
